cordic_sequencer: RTL and testbench

CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

---
 rtl/cordic_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cordic_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sequencer.sv
// Iterative rotation-mode CORDIC: a quadrant fold followed by ITERATIONS micro-rotations.
// The angle on z is scaled so that 2^26 LSB = pi rad. All arithmetic wraps at 27 bits.
module cordic_sequencer #(
  parameter int unsigned ITERATIONS = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic signed [26:0] x_in,
  input  logic signed [26:0] y_in,
  input  logic signed [26:0] z_in,
  output logic               busy,
  output logic               done,
  output logic signed [26:0] x_out,
  output logic signed [26:0] y_out,
  output logic signed [26:0] z_out
);

  typedef enum logic [1:0] {StIdle, StFold, StIter, StFin} state_e;

  localparam logic [4:0]        LastIdx = 5'(ITERATIONS - 1);
  localparam logic signed [26:0] HalfPi = 27'sd33554432;

  // round(atan(2^-i) / pi * 2^26)
  function automatic logic signed [26:0] atan_lut(input logic [4:0] idx);
    logic signed [26:0] v;
    case (idx)
      5'd0:    v = 27'sd16777216;
      5'd1:    v = 27'sd9904169;
      5'd2:    v = 27'sd5233091;
      5'd3:    v = 27'sd2656399;
      5'd4:    v = 27'sd1333354;
      5'd5:    v = 27'sd667327;
      5'd6:    v = 27'sd333745;
      5'd7:    v = 27'sd166883;
      5'd8:    v = 27'sd83443;
      5'd9:    v = 27'sd41721;
      5'd10:   v = 27'sd20861;
      5'd11:   v = 27'sd10430;
      5'd12:   v = 27'sd5215;
      5'd13:   v = 27'sd2608;
      5'd14:   v = 27'sd1304;
      5'd15:   v = 27'sd652;
      5'd16:   v = 27'sd326;
      5'd17:   v = 27'sd163;
      5'd18:   v = 27'sd81;
      5'd19:   v = 27'sd41;
      5'd20:   v = 27'sd20;
      5'd21:   v = 27'sd10;
      5'd22:   v = 27'sd5;
      5'd23:   v = 27'sd3;
      5'd24:   v = 27'sd1;
      5'd25:   v = 27'sd1;
      default: v = 27'sd0;
    endcase
    return v;
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         i_q, i_d;
  logic signed [26:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [26:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic signed [26:0] x_sh, y_sh, atan_i;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_sh    = x_q >>> i_q;
    y_sh    = y_q >>> i_q;
    atan_i  = atan_lut(i_q);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = StFold;
        end
      end
      StFold: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          // Bring z into [-pi/2, pi/2) so the micro-rotations can converge.
          if (z_q[26:25] == 2'b01) begin
            x_d = -y_q;
            y_d = x_q;
            z_d = z_q - HalfPi;
          end else if (z_q[26:25] == 2'b10) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = z_q + HalfPi;
          end
          state_d = StIter;
        end
      end
      StIter: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          if (z_q[26]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
          end
          i_d = i_q + 5'd1;
          if (i_q == LastIdx) state_d = StFin;
        end
      end
      StFin: begin
        xo_d    = x_q;
        yo_d    = y_q;
        zo_d    = z_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = xo_q;
  assign y_out = yo_q;
  assign z_out = zo_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: accuracy table against trigonometric targets, random operands
// against an arithmetic reference model, and hand sequences for start/abort/reset corners.
module tb_cordic_sequencer;

  localparam int unsigned N = 24;

  logic               clk = 1'b0;
  logic               rst, start, abort;
  logic signed [26:0] x_in, y_in, z_in;
  logic               busy, done;
  logic signed [26:0] x_out, y_out, z_out;

  int vectors = 0;
  int miscompares = 0;
  longint atan_tab[26];

  cordic_sequencer #(.ITERATIONS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string  name;
    longint x, y, z;
    longint ex, ey;
  } vec_t;

  function automatic longint w27(input longint v);
    logic signed [26:0] t;
    t = v[26:0];
    return longint'(t);
  endfunction

  // Reference: fold into [-pi/2, pi/2), then N signed-digit rotations with wrap at 27 bits.
  function automatic void model(input longint xi, yi, zi, output longint xo, yo, zo);
    longint x, y, z, t, dx, dy;
    x = xi; y = yi; z = zi;
    if (z >= 33554432) begin
      t = x; x = w27(-y); y = t; z = w27(z - 33554432);
    end else if (z < -33554432) begin
      t = x; x = y; y = w27(-t); z = w27(z + 33554432);
    end
    for (int i = 0; i < int'(N); i++) begin
      dx = y >>> i;
      dy = x >>> i;
      if (z < 0) begin
        x = w27(x + dx); y = w27(y - dy); z = w27(z + atan_tab[i]);
      end else begin
        x = w27(x - dx); y = w27(y + dy); z = w27(z - atan_tab[i]);
      end
    end
    xo = x; yo = y; zo = z;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp,
                           input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    vectors++;
    if (d > tol) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input longint x, y, z);
    x_in  = 27'(x);
    y_in  = 27'(y);
    z_in  = 27'(z);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick;
      cyc++;
    end
  endtask

  task automatic check_model(input string name, input longint x, y, z);
    longint mx, my, mz;
    model(x, y, z, mx, my, mz);
    check({name, ".x"}, x_out, mx);
    check({name, ".y"}, y_out, my);
    check({name, ".z"}, z_out, mz);
  endtask

  task automatic run_check(input string name, input longint x, y, z);
    int c;
    start_op(x, y, z);
    check({name, ".busy"}, busy, 1);
    wait_done(c);
    check({name, ".lat"}, c, N + 2);
    check_model(name, x, y, z);
  endtask

  initial begin
    vec_t   tab[8];
    longint px, py, pz, rx, ry, rz;
    int     c, ndone, first;
    logic [26:0] r;

    for (int i = 0; i < 26; i++)
      atan_tab[i] = longint'($rtoi($atan(1.0 / (2.0 ** i)) / 3.141592653589793 * 67108864.0
                                    + 0.5));

    tab[0] = '{"rot0",    10188014, 0,        0,         16777216,  0};
    tab[1] = '{"pi4",     10188014, 0,        16777216,  11863283,  11863283};
    tab[2] = '{"pi2",     10188014, 0,        33554432,  0,         16777216};
    tab[3] = '{"mpi2",    10188014, 0,        -33554432, 0,         -16777216};
    tab[4] = '{"mpi4",    10188014, 0,        -16777216, 11863283,  -11863283};
    tab[5] = '{"p3pi4",   10188014, 0,        50331648,  -11863283, 11863283};
    tab[6] = '{"m3pi4",   10188014, 0,        -50331648, -11863283, -11863283};
    tab[7] = '{"yonly",   0,        10188014, 0,         0,         16777216};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    tick;
    tick;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.x_out", x_out, 0);
    check("reset.y_out", y_out, 0);
    check("reset.z_out", z_out, 0);
    rst = 1'b0;

    // Accuracy against the analytic rotation of (2^24/K, 0).
    for (int k = 0; k < 8; k++) begin
      start_op(tab[k].x, tab[k].y, tab[k].z);
      wait_done(c);
      check({tab[k].name, ".lat"}, c, N + 2);
      check_tol({tab[k].name, ".x_out"}, x_out, tab[k].ex, 32);
      check_tol({tab[k].name, ".y_out"}, y_out, tab[k].ey, 32);
      check_tol({tab[k].name, ".z_out"}, z_out, 0, 8);
      check_model(tab[k].name, tab[k].x, tab[k].y, tab[k].z);
      tick;
      check({tab[k].name, ".done_1cyc"}, done, 0);
    end

    // Random operands, first one at the wrap-around extreme.
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin
        rx = -67108864; ry = -67108864; rz = 33554432;
      end else begin
        r = 27'($urandom); rx = longint'($signed(r));
        r = 27'($urandom); ry = longint'($signed(r));
        r = 27'($urandom); rz = longint'($signed(r));
      end
      run_check($sformatf("rand%0d", k), rx, ry, rz);
    end

    // Start pulses during an operation are ignored.
    start_op(10188014, 0, 16777216);
    ndone = 0; first = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start = (cyc == 5 || cyc == 10);
      x_in = 27'sd1234567; y_in = 27'sd7654321; z_in = -27'sd9999999;
      tick;
      if (done) begin
        ndone++;
        if (first == 0) first = cyc;
      end
    end
    start = 1'b0;
    check("ignore_start.ndone", ndone, 1);
    check("ignore_start.lat", first, N + 2);
    check_model("ignore_start", 10188014, 0, 16777216);

    // Back-to-back: start raised as soon as done is seen.
    start_op(3000000, -2000000, 20000000);
    wait_done(c);
    run_check("b2b", -5000000, 4000000, -40000000);

    // Abort at ITER i=7 leaves previous outputs, no done.
    px = x_out; py = y_out; pz = z_out;
    start_op(10188014, 0, 0);
    repeat (8) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort.busy", busy, 0);
    ndone = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done) ndone++;
      tick;
    end
    check("abort.ndone", ndone, 0);
    check("abort.x_out", x_out, px);
    check("abort.y_out", y_out, py);
    check("abort.z_out", z_out, pz);

    // Abort together with start in ITER: aborted, start not taken.
    start_op(10188014, 0, 0);
    repeat (3) tick;
    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    check("abort_start.busy", busy, 0);
    ndone = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done) ndone++;
      tick;
    end
    check("abort_start.ndone", ndone, 0);
    check("abort_start.x_out", x_out, px);

    // Abort in FIN is ignored.
    start_op(10188014, 0, -16777216);
    repeat (N + 1) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_fin.done", done, 1);
    check_model("abort_fin", 10188014, 0, -16777216);

    // Reset mid-ITER clears everything; start on the first edge after reset works.
    start_op(10188014, 0, 16777216);
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.x_out", x_out, 0);
    check("midrst.y_out", y_out, 0);
    check("midrst.z_out", z_out, 0);
    run_check("post_rst", 10188014, 0, 33554432);
    check_tol("post_rst.y_acc", y_out, 16777216, 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
